// File: rtl/lp_pkg.sv
// Shared types and constants for the lp first-order IIR lowpass.
// Provides the FSM state enum, datapath widths, the rounding bias and
// a width-parameterised signed saturation helper.
package lp_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned COEF_W = 16;
    localparam int unsigned D_W    = DATA_W + 1;
    localparam int unsigned P_W    = DATA_W + COEF_W + 2;

    // Half an LSB of the output scale, added before the >>> COEF_W.
    localparam logic signed [P_W-1:0] ROUND_BIAS = P_W'(1) <<< (COEF_W - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUB  = 3'd1,
        MUL  = 3'd2,
        ACC  = 3'd3,
        HOLD = 3'd4
    } state_t;

    // Clamp v to the range of a w-bit signed value (w <= 63).
    function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                               input int unsigned       w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)      sat = hi;
        else if (v < lo) sat = lo;
        else             sat = v;
    endfunction

endpackage

// File: rtl/lp_if.sv
// Sample stream interface for lp.
// Input side:  i_valid/o_ready handshake carrying i_data, i_ch, i_coef.
// Output side: o_valid/i_ready handshake carrying o_data, o_ch.
// o_err flags a dropped sample with an illegal channel index.
// master = upstream/downstream environment, slave = the filter.
interface lp_if
    import lp_pkg::*;
#(
    parameter int unsigned CH_W = 1
);
    logic [COEF_W-1:0]        i_coef;
    logic                     i_valid;
    logic                     o_ready;
    logic signed [DATA_W-1:0] i_data;
    logic [CH_W-1:0]          i_ch;
    logic                     o_valid;
    logic                     i_ready;
    logic signed [DATA_W-1:0] o_data;
    logic [CH_W-1:0]          o_ch;
    logic                     o_err;

    modport master (
        output i_coef, i_valid, i_data, i_ch, i_ready,
        input  o_ready, o_valid, o_data, o_ch, o_err
    );

    modport slave (
        input  i_coef, i_valid, i_data, i_ch, i_ready,
        output o_ready, o_valid, o_data, o_ch, o_err
    );
endinterface

// File: rtl/lp_state_mem.sv
// Per-channel filter state (previous output y[n-1]).
// Ports: i_clk, i_rst (sync, active-high, clears all entries),
//        we/ch/wdata write port, rdata_c combinational read of entry ch.
module lp_state_mem
    import lp_pkg::*;
#(
    parameter int unsigned N_CH = 2,
    parameter int unsigned CH_W = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     we,
    input  logic [CH_W-1:0]          ch,
    input  logic signed [DATA_W-1:0] wdata,
    output logic signed [DATA_W-1:0] rdata_c
);

    logic signed [DATA_W-1:0] mem [N_CH];

    // Register file; reset wins over a concurrent write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(N_CH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[ch] <= wdata;
        end
    end

    assign rdata_c = mem[ch];

endmodule

// File: rtl/lp.sv
// Time-multiplexed first-order IIR lowpass: y = y_prev + a*(x - y_prev),
// a = i_coef / 2^COEF_W, one state per channel, one sample in flight.
// Ports: i_clk, i_rst (sync, active-high), bus (lp_if.slave):
//   input stream  i_valid/o_ready, i_data, i_ch, i_coef
//   output stream o_valid/i_ready, o_data, o_ch
//   o_err one-cycle pulse when a sample with i_ch >= N_CH is dropped.
module lp
    import lp_pkg::*;
#(
    parameter  int unsigned N_CH = 2,
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input logic i_clk,
    input logic i_rst,
    lp_if.slave bus
);

    state_t state_q;
    state_t state_d;

    logic signed [DATA_W-1:0] x_q;
    logic [COEF_W-1:0]        coef_q;
    logic [CH_W-1:0]          ch_q;
    logic signed [D_W-1:0]    d_q;
    logic signed [P_W-1:0]    p_q;

    logic signed [DATA_W-1:0] y_prev_c;
    logic signed [P_W-1:0]    p_rnd_c;
    logic signed [63:0]       y_wide_c;
    logic signed [DATA_W-1:0] y_sat_c;

    logic accept_c;
    logic illegal_c;
    logic load_c;
    logic mem_we_c;
    logic ready_d;
    logic valid_d;
    logic err_d;

    assign accept_c  = bus.i_valid && bus.o_ready;
    assign illegal_c = 32'(bus.i_ch) >= N_CH;

    lp_state_mem #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_state_mem (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .we      (mem_we_c),
        .ch      (ch_q),
        .wdata   (y_sat_c),
        .rdata_c (y_prev_c)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; illegal-channel samples leave the FSM in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c && !illegal_c) state_d = SUB;
            SUB:     state_d = MUL;
            MUL:     state_d = ACC;
            ACC:     state_d = HOLD;
            HOLD:    if (bus.i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/control decode; ready and valid are registered decodes of the next state.
    always_comb begin
        ready_d  = (state_d == IDLE);
        valid_d  = (state_d == HOLD);
        err_d    = (state_q == IDLE) && accept_c && illegal_c;
        load_c   = (state_q == IDLE) && accept_c && !illegal_c;
        mem_we_c = (state_q == ACC);
    end

    // Round-half-up, arithmetic shift back to sample scale, accumulate, saturate.
    always_comb begin
        p_rnd_c  = p_q + ROUND_BIAS;
        y_wide_c = 64'(y_prev_c) + 64'(p_rnd_c >>> COEF_W);
        y_sat_c  = DATA_W'(sat(y_wide_c, DATA_W));
    end

    // Datapath and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_ready <= 1'b1;
            bus.o_valid <= 1'b0;
            bus.o_err   <= 1'b0;
            bus.o_data  <= '0;
            bus.o_ch    <= '0;
            x_q         <= '0;
            coef_q      <= '0;
            ch_q        <= '0;
            d_q         <= '0;
            p_q         <= '0;
        end else begin
            bus.o_ready <= ready_d;
            bus.o_valid <= valid_d;
            bus.o_err   <= err_d;
            if (load_c) begin
                x_q    <= bus.i_data;
                coef_q <= bus.i_coef;
                ch_q   <= bus.i_ch;
            end
            if (state_q == SUB) begin
                d_q <= D_W'(x_q) - D_W'(y_prev_c);
            end
            if (state_q == MUL) begin
                // Coefficient is unsigned: zero-extend before the signed multiply.
                p_q <= P_W'(d_q) * P_W'($signed({1'b0, coef_q}));
            end
            if (state_q == ACC) begin
                bus.o_data <= y_sat_c;
                bus.o_ch   <= ch_q;
            end
        end
    end

endmodule
